// File: rtl/aurora_bist_pkg.sv
// aurora_bist_pkg: shared PRBS31 sequence definition and checker types for the Aurora BIST pair
package aurora_bist_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } bist_chk_state_t;

   localparam int BIST_WORD_W = 64;

   // Next 64 bits of b[n] = b[n-31] ^ b[n-28], seeded by w[30:0] (w[0] is the newest bit).
   // The result has its earliest bit in [63].
   function automatic logic [63:0] prbs31_next64(input logic [63:0] w);
      logic [94:0] s;
      logic [63:0] r;
      s = '0;
      r = '0;
      for (int i = 0; i < 31; i++) s[i] = w[30-i];
      for (int i = 31; i < 95; i++) s[i] = s[i-31] ^ s[i-28];
      for (int j = 0; j < 64; j++) r[63-j] = s[31+j];
      return r;
   endfunction

   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) c = c + {6'd0, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/aurora_bist_sat_counter.sv
// aurora_bist_sat_counter: saturating accumulator with synchronous clear and an increment input
module aurora_bist_sat_counter #(
   parameter int W     = 48,
   parameter int INC_W = 1
) (
   input  logic             phy_clk,
   input  logic             phy_rst_n,
   input  logic             clr,
   input  logic [INC_W-1:0] inc,
   output logic [W-1:0]     cnt
);

   logic [W:0] sum;

   // One extra bit so the carry out marks saturation
   always_comb sum = {1'b0, cnt} + {{(W + 1 - INC_W){1'b0}}, inc};

   // Clear wins; otherwise accumulate and clamp at all-ones
   always_ff @(posedge phy_clk or negedge phy_rst_n)
      if (!phy_rst_n) cnt <= '0;
      else            cnt <= clr ? '0 : (sum[W] ? '1 : sum[W-1:0]);

endmodule

// File: rtl/aurora_bist_prbs_checker.sv
// aurora_bist_prbs_checker: self-synchronising PRBS31 receive checker with lock status and
// saturating sample/error counters. Define AURORA_BIST_BITERR_EN to count bit errors
// instead of word errors.
module aurora_bist_prbs_checker
   import aurora_bist_pkg::*;
#(
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 8,
   parameter int CNT_W      = 48
) (
   input  logic                   phy_clk,
   input  logic                   phy_rst_n,
   input  logic                   checker_en,
   input  logic [BIST_WORD_W-1:0] s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   locked,
   output logic                   lock_lost,
   output logic [CNT_W-1:0]       samps,
   output logic [CNT_W-1:0]       errors
);

   localparam int MW = $clog2(LOCK_CNT) + 1;
   localparam int UW = $clog2(UNLOCK_CNT) + 1;
   localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_CNT - 1);
   localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_CNT - 1);
`ifdef AURORA_BIST_BITERR_EN
   localparam int EW = 7;
`else
   localparam int EW = 1;
`endif

   logic                   en_q;
   logic                   en_prev;
   logic                   v_q;
   logic [BIST_WORD_W-1:0] d_q;
   logic [BIST_WORD_W-1:0] ref_w;
   logic [BIST_WORD_W-1:0] pred;
   bist_chk_state_t        state;
   logic [MW-1:0]          match_cnt;
   logic [UW-1:0]          miss_cnt;
   logic                   rise;
   logic                   hit;
   logic                   samp_inc;
   logic [EW-1:0]          err_inc;

   // Register the raw inputs once; the previous enable sample gives the rising-edge detect
   always_ff @(posedge phy_clk or negedge phy_rst_n)
      if (!phy_rst_n) begin
         en_q    <= 1'b0;
         en_prev <= 1'b0;
         v_q     <= 1'b0;
         d_q     <= '0;
      end else begin
         en_q    <= checker_en;
         en_prev <= en_q;
         v_q     <= s_axis_tvalid;
         d_q     <= s_axis_tdata;
      end

   // Predict from the reference word; an all-zero seed can never match
   always_comb begin
      pred     = prbs31_next64(ref_w);
      hit      = (ref_w[30:0] != '0) && (d_q == pred);
      rise     = en_q && !en_prev;
      samp_inc = en_q && v_q && (state == LOCKED);
`ifdef AURORA_BIST_BITERR_EN
      err_inc  = (samp_inc && !hit) ? popcount64(d_q ^ pred) : '0;
`else
      err_inc  = samp_inc && !hit;
`endif
   end

   // Search/lock state machine; the reference follows received words while searching and
   // its own predictions while locked so a bad word never poisons the next prediction
   always_ff @(posedge phy_clk or negedge phy_rst_n)
      if (!phy_rst_n) begin
         state     <= IDLE;
         ref_w     <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         lock_lost <= 1'b0;
      end else if (!en_q) begin
         state <= IDLE;
      end else if (rise) begin
         state     <= SEARCH;
         ref_w     <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         lock_lost <= 1'b0;
      end else if (v_q && state == SEARCH) begin
         ref_w <= d_q;
         if (!hit) begin
            match_cnt <= '0;
         end else if (match_cnt == LOCK_LAST) begin
            state     <= LOCKED;
            match_cnt <= '0;
            miss_cnt  <= '0;
         end else begin
            match_cnt <= match_cnt + 1'b1;
         end
      end else if (v_q && state == LOCKED) begin
         if (hit) begin
            miss_cnt <= '0;
            ref_w    <= pred;
         end else if (miss_cnt == UNLOCK_LAST) begin
            state     <= SEARCH;
            lock_lost <= 1'b1;
            ref_w     <= d_q;
            match_cnt <= '0;
            miss_cnt  <= '0;
         end else begin
            miss_cnt <= miss_cnt + 1'b1;
            ref_w    <= pred;
         end
      end

   // Lock indication trails the state by one edge
   always_ff @(posedge phy_clk or negedge phy_rst_n)
      if (!phy_rst_n) locked <= 1'b0;
      else            locked <= (state == LOCKED);

   aurora_bist_sat_counter #(.W(CNT_W), .INC_W(1)) u_samps (
      .phy_clk   (phy_clk),
      .phy_rst_n (phy_rst_n),
      .clr       (rise),
      .inc       (samp_inc),
      .cnt       (samps)
   );

   aurora_bist_sat_counter #(.W(CNT_W), .INC_W(EW)) u_errors (
      .phy_clk   (phy_clk),
      .phy_rst_n (phy_rst_n),
      .clr       (rise),
      .inc       (err_inc),
      .cnt       (errors)
   );

endmodule

// File: tb/tb_aurora_bist_prbs_checker.sv
// tb_aurora_bist_prbs_checker: table-driven and randomized bench for the PRBS31 checker
module tb_aurora_bist_prbs_checker;

   logic        phy_clk       = 1'b0;
   logic        phy_rst_n     = 1'b0;
   logic        checker_en    = 1'b0;
   logic [63:0] s_axis_tdata  = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        locked;
   logic        lock_lost;
   logic [47:0] samps;
   logic [47:0] errors;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        lk;
      logic        lost;
      logic [47:0] sm;
      logic [47:0] er;
   } snap_t;

   typedef struct {
      int          ncyc;
      bit          gap;
      bit          zero;
      int          c_at;
      int          c_len;
      logic [63:0] c_mask;
      logic        e_locked;
      logic        e_lost;
      logic [47:0] e_samps;
      logic [47:0] e_errors;
      string       name;
   } vec_t;

   snap_t       hist [3];
   int          m_state;
   int          m_match;
   int          m_miss;
   logic        m_en_prev;
   logic [63:0] m_prev;
   logic [47:0] m_samps;
   logic [47:0] m_errors;
   logic        m_lost;
   logic [63:0] g_w = 64'h1;

   always #5 phy_clk = ~phy_clk;

   aurora_bist_prbs_checker dut (
      .phy_clk       (phy_clk),
      .phy_rst_n     (phy_rst_n),
      .checker_en    (checker_en),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .locked        (locked),
      .lock_lost     (lock_lost),
      .samps         (samps),
      .errors        (errors)
   );

   // Bit-serial PRBS31: shift the newest 31 bits, emit 64 new bits earliest-first
   function automatic logic [63:0] ref_next(input logic [63:0] w);
      logic [30:0] h;
      logic [63:0] r;
      logic        nb;
      h = w[30:0];
      r = '0;
      for (int i = 0; i < 64; i++) begin
         nb = h[30] ^ h[27];
         h  = {h[29:0], nb};
         r  = {r[62:0], nb};
      end
      return r;
   endfunction

   function automatic logic [47:0] sat_add(input logic [47:0] a, input int unsigned b);
      logic [48:0] s;
      s = {1'b0, a} + 49'(b);
      return s[48] ? '1 : s[47:0];
   endfunction

   task automatic gen(output logic [63:0] w);
      g_w = ref_next(g_w);
      w   = g_w;
   endtask

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state   = 0;
      m_match   = 0;
      m_miss    = 0;
      m_en_prev = 1'b0;
      m_prev    = '0;
      m_samps   = '0;
      m_errors  = '0;
      m_lost    = 1'b0;
      for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 1'b0, 48'h0, 48'h0};
   endtask

   // Word-level reference: 0 idle, 1 searching, 2 locked
   task automatic model_step(input logic en, input logic v, input logic [63:0] d);
      logic [63:0] p;
      logic        good;
      int unsigned inc;
      p    = ref_next(m_prev);
      good = (m_prev[30:0] != 0) && (d == p);
`ifdef AURORA_BIST_BITERR_EN
      inc  = $countones(d ^ p);
`else
      inc  = 1;
`endif
      if (!en) begin
         m_state = 0;
      end else if (!m_en_prev) begin
         m_state  = 1;
         m_match  = 0;
         m_miss   = 0;
         m_prev   = '0;
         m_samps  = '0;
         m_errors = '0;
         m_lost   = 1'b0;
      end else if (v && m_state == 1) begin
         m_prev  = d;
         m_match = good ? m_match + 1 : 0;
         if (m_match == 16) begin
            m_state = 2;
            m_miss  = 0;
            m_match = 0;
         end
      end else if (v && m_state == 2) begin
         m_samps = sat_add(m_samps, 1);
         if (good) begin
            m_miss = 0;
            m_prev = p;
         end else begin
            m_errors = sat_add(m_errors, inc);
            m_miss++;
            if (m_miss == 8) begin
               m_state = 1;
               m_lost  = 1'b1;
               m_match = 0;
               m_miss  = 0;
               m_prev  = d;
            end else begin
               m_prev = p;
            end
         end
      end
      m_en_prev = en;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{(m_state == 2), m_lost, m_samps, m_errors};
   endtask

   // Counters and lock_lost show a word two edges after it is driven, locked one edge later
   task automatic step(input logic en, input logic v, input logic [63:0] d);
      @(negedge phy_clk);
      check("locked", locked, hist[2].lk);
      check("lock_lost", lock_lost, hist[1].lost);
      check("samps", samps, hist[1].sm);
      check("errors", errors, hist[1].er);
      checker_en    = en;
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      model_step(en, v, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, {$urandom, $urandom});
   endtask

   task automatic restart();
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, {$urandom, $urandom});
   endtask

   task automatic do_reset();
      @(negedge phy_clk);
      #2 phy_rst_n = 1'b0;
      #1;
      check("rst_locked", locked, 0);
      check("rst_lock_lost", lock_lost, 0);
      check("rst_samps", samps, 0);
      check("rst_errors", errors, 0);
      checker_en    = 1'b0;
      s_axis_tvalid = 1'b0;
      repeat (2) @(negedge phy_clk);
      phy_rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      vec_t        tbl [5];
      logic        v;
      logic        en;
      logic [63:0] d;
      int          burst;
      tbl[0] = '{273, 1'b0, 1'b0, -1, 0, 64'h0,      1'b1, 1'b0, 48'd256, 48'd0, "clean"};
      tbl[1] = '{60,  1'b0, 1'b0, 40, 1, 64'h20,     1'b1, 1'b0, 48'd43,  48'd1, "flip5"};
      tbl[2] = '{100, 1'b0, 1'b0, 30, 8, 64'h1,      1'b1, 1'b1, 48'd66,  48'd8, "unlock"};
      tbl[3] = '{80,  1'b1, 1'b0, -1, 0, 64'h0,      1'b1, 1'b0, 48'd23,  48'd0, "gap"};
      tbl[4] = '{100, 1'b0, 1'b1, -1, 0, 64'h0,      1'b0, 1'b0, 48'd0,   48'd0, "zeros"};
      burst = 0;
      model_reset();
      repeat (3) @(negedge phy_clk);
      check("init_locked", locked, 0);
      check("init_lock_lost", lock_lost, 0);
      check("init_samps", samps, 0);
      check("init_errors", errors, 0);
      phy_rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         restart();
         for (int i = 0; i < tbl[k].ncyc; i++) begin
            v = !tbl[k].gap || (i % 4 == 0) || (i % 4 == 3);
            d = {$urandom, $urandom};
            if (v && !tbl[k].zero) gen(d);
            if (tbl[k].zero) d = '0;
            if (i >= tbl[k].c_at && i < tbl[k].c_at + tbl[k].c_len) d = d ^ tbl[k].c_mask;
            step(1'b1, v, d);
            if (k == 0 && i == 18) check("lock_time_early", locked, 0);
            if (k == 0 && i == 19) check("lock_time", locked, 1);
         end
         idle(4);
         check({tbl[k].name, "_locked"}, locked, tbl[k].e_locked);
         check({tbl[k].name, "_lock_lost"}, lock_lost, tbl[k].e_lost);
         check({tbl[k].name, "_samps"}, samps, tbl[k].e_samps);
         check({tbl[k].name, "_errors"}, errors, tbl[k].e_errors);
      end
      restart();
      for (int i = 0; i < 30; i++) begin
         gen(d);
         step(1'b1, 1'b1, d);
      end
      idle(3);
      @(negedge phy_clk);
      force dut.u_samps.cnt = 48'hFFFF_FFFF_FFFB;
      @(negedge phy_clk);
      release dut.u_samps.cnt;
      m_samps = 48'hFFFF_FFFF_FFFB;
      for (int i = 0; i < 3; i++) hist[i].sm = m_samps;
      for (int i = 0; i < 10; i++) begin
         gen(d);
         step(1'b1, 1'b1, d);
      end
      idle(3);
      check("samps_sat", samps, 48'hFFFF_FFFF_FFFF);
      for (int i = 0; i < 8; i++) begin
         gen(d);
         step(1'b1, 1'b1, d ^ 64'h1);
      end
      idle(4);
      check("sat_unlock_lost", lock_lost, 1);
      check("sat_unlock_errors", errors, 8);
      check("sat_unlock_locked", locked, 0);
      restart();
      idle(3);
      check("reen_samps", samps, 0);
      check("reen_errors", errors, 0);
      check("reen_lock_lost", lock_lost, 0);
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         en = ($urandom_range(399) != 0);
         v  = ($urandom_range(3) != 0);
         d  = {$urandom, $urandom};
         if (v) begin
            gen(d);
            if ($urandom_range(15) == 0) d = d ^ (64'h1 << $urandom_range(63));
            if (burst > 0) begin
               d = d ^ ({$urandom, $urandom} | 64'h1);
               burst--;
            end else if ($urandom_range(299) == 0) begin
               burst = 10;
            end
         end
         step(en, v, d);
      end
      idle(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
